// File: rtl/i2s_tdm_receiver_if.sv
// Output stream of the serial-audio receiver: channel-tagged words under valid/ready.
// The producer drives data/ch/valid and the consumer answers with ready.
interface i2s_tdm_receiver_if #(
    parameter int unsigned WORD_LEN = 24,
    parameter int unsigned NUM_CH   = 8
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [WORD_LEN-1:0] data;
    logic [CH_W-1:0]     ch;
    logic                valid;
    logic                ready;

    modport master (
        output data,
        output ch,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  ch,
        input  valid,
        output ready
    );
endinterface

// File: rtl/i2s_tdm_receiver.sv
// I2S / left-justified / TDM (DSP mode A) receiver: synchronises the serial pins into clk_i,
// deserialises each channel word MSB first and queues {channel, word} in a fall-through FIFO.
module i2s_tdm_receiver #(
    parameter int unsigned WORD_LEN   = 24,
    parameter int unsigned SLOT_LEN   = 32,
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [1:0]                    mode_i,
    input  logic                          bclk_i,
    input  logic                          ws_i,
    input  logic                          sd_i,
    i2s_tdm_receiver_if.master            out_if,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic                          sync_err_o
);
    localparam int unsigned CH_W    = $clog2(NUM_CH);
    localparam int unsigned CNT_W   = $clog2(SLOT_LEN + 1);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = CH_W + WORD_LEN;

    localparam logic [1:0] StSearch  = 2'd0;
    localparam logic [1:0] StArm     = 2'd1;
    localparam logic [1:0] StReceive = 2'd2;

    localparam logic [CNT_W-1:0] WordLen  = CNT_W'(WORD_LEN);
    localparam logic [CNT_W-1:0] WordLast = CNT_W'(WORD_LEN - 1);
    localparam logic [CNT_W-1:0] SlotLen  = CNT_W'(SLOT_LEN);
    localparam logic [CNT_W-1:0] SlotLast = CNT_W'(SLOT_LEN - 1);
    localparam logic [CH_W-1:0]  ChLast   = CH_W'(NUM_CH - 1);
    localparam logic [LVL_W-1:0] Depth    = LVL_W'(FIFO_DEPTH);

    if (WORD_LEN < 2 || WORD_LEN > SLOT_LEN) begin : g_bad_word_len
        $error("WORD_LEN must lie in 2..SLOT_LEN");
    end
    if (NUM_CH < 2) begin : g_bad_num_ch
        $error("NUM_CH must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0] bclk_sync_q;
    logic [1:0] ws_sync_q;
    logic [1:0] sd_sync_q;
    logic       bclk_prev_q;
    logic       ws_prev_q;

    logic bclk_rise;
    logic ws_s;
    logic sd_s;

    assign bclk_rise = bclk_sync_q[1] & ~bclk_prev_q;
    assign ws_s      = ws_sync_q[1];
    assign sd_s      = sd_sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bclk_sync_q <= '0;
            ws_sync_q   <= '0;
            sd_sync_q   <= '0;
            bclk_prev_q <= 1'b0;
            ws_prev_q   <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[0], bclk_i};
            ws_sync_q   <= {ws_sync_q[0], ws_i};
            sd_sync_q   <= {sd_sync_q[0], sd_i};
            bclk_prev_q <= bclk_sync_q[1];
            if (bclk_rise) begin
                ws_prev_q <= ws_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Framing state machine
    // ------------------------------------------------------------------
    logic                is_tdm;
    logic                is_lj;
    logic                frame_evt;

    assign is_tdm    = mode_i[1];
    assign is_lj     = (mode_i == 2'd1);
    assign frame_evt = is_tdm ? (ws_s & ~ws_prev_q) : (ws_s ^ ws_prev_q);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [WORD_LEN-1:0] shift_q, shift_d;
    logic                sync_err_q, sync_err_d;
    logic                push;
    logic                do_start;
    logic                last_slot_end;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        shift_d    = shift_q;
        push       = 1'b0;
        sync_err_d = 1'b0;
        do_start   = 1'b0;
        // A TDM frame sync coinciding with the final bit of the last slot is a legal
        // back-to-back frame start, not a mid-frame resync.
        last_slot_end = is_tdm && (ch_q == ChLast) && (cnt_q == SlotLast);

        if (!enable_i) begin
            state_d = StSearch;
            cnt_d   = '0;
            shift_d = '0;
        end else if (bclk_rise) begin
            case (state_q)
                StSearch: begin
                    do_start = frame_evt;
                end
                StArm: begin
                    state_d = StReceive;
                    cnt_d   = CNT_W'(1);
                    shift_d = {{(WORD_LEN - 1){1'b0}}, sd_s};
                end
                StReceive: begin
                    if (frame_evt && !last_slot_end) begin
                        do_start   = 1'b1;
                        sync_err_d = is_tdm || (cnt_q < WordLen);
                    end else begin
                        if (cnt_q < WordLen) begin
                            shift_d = {shift_q[WORD_LEN-2:0], sd_s};
                            push    = (cnt_q == WordLast);
                        end
                        if (cnt_q < SlotLen) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if (is_tdm && (cnt_q == SlotLast)) begin
                            cnt_d = '0;
                            if (ch_q == ChLast) begin
                                ch_d    = '0;
                                state_d = frame_evt ? StArm : StSearch;
                            end else begin
                                ch_d = ch_q + CH_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = StSearch;
                end
            endcase

            // Slot (re)start shared by SEARCH and in-RECEIVE frame events
            if (do_start) begin
                ch_d = is_tdm ? '0 : CH_W'(ws_s);
                if (is_lj) begin
                    state_d = StReceive;
                    cnt_d   = CNT_W'(1);
                    shift_d = {{(WORD_LEN - 1){1'b0}}, sd_s};
                end else begin
                    state_d = StArm;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StSearch;
            cnt_q      <= '0;
            ch_q       <= '0;
            shift_q    <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            shift_q    <= shift_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign sync_err_o = sync_err_q;

    // ------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LVL_W-1:0]   count_q;
    logic               overflow_q;

    logic full;
    logic empty;
    logic pop;
    logic do_write;

    assign full     = (count_q == Depth);
    assign empty    = (count_q == '0);
    assign pop      = ~empty & out_if.ready;
    assign do_write = push & (~full | pop);

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= {ch_q, shift_d};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_write && !pop) begin
                count_q <= count_q + LVL_W'(1);
            end else if (pop && !do_write) begin
                count_q <= count_q - LVL_W'(1);
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Head entry is masked while empty so the outputs read zero after reset
    assign out_if.valid = ~empty;
    assign out_if.data  = empty ? '0 : mem_q[rd_ptr_q][WORD_LEN-1:0];
    assign out_if.ch    = empty ? '0 : mem_q[rd_ptr_q][ENTRY_W-1 -: CH_W];
    assign level_o      = count_q;
    assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_i2s_tdm_receiver.sv
// Scoreboard bench for i2s_tdm_receiver: drives I2S, LJ and TDM pin patterns, queues the
// expected {channel, word} stream and checks it as the FIFO drains.
module tb_i2s_tdm_receiver;
    localparam int unsigned WORD_LEN   = 24;
    localparam int unsigned SLOT_LEN   = 32;
    localparam int unsigned NUM_CH     = 8;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned HALF       = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic       bclk;
    logic       ws;
    logic       sd;
    logic [3:0] level;
    logic       overflow;
    logic       sync_err;

    always #5 clk = ~clk;

    i2s_tdm_receiver_if #(.WORD_LEN(WORD_LEN), .NUM_CH(NUM_CH)) out_if ();

    i2s_tdm_receiver #(
        .WORD_LEN  (WORD_LEN),
        .SLOT_LEN  (SLOT_LEN),
        .NUM_CH    (NUM_CH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .enable_i  (enable),
        .mode_i    (mode),
        .bclk_i    (bclk),
        .ws_i      (ws),
        .sd_i      (sd),
        .out_if    (out_if),
        .level_o   (level),
        .overflow_o(overflow),
        .sync_err_o(sync_err)
    );

    typedef struct {
        logic [2:0]  ch;
        logic [23:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks      = 0;
    int   failures    = 0;
    int   err_pulses  = 0;
    int   err_base;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input int c, input logic [23:0] w);
        exp_t e;
        e.ch   = 3'(c);
        e.data = w;
        sb.push_back(e);
    endtask

    // Output side: compare each accepted word with the head of the scoreboard
    always @(negedge clk) begin
        if (sync_err) err_pulses++;
        if (out_if.valid && out_if.ready) begin
            check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check_eq("word_data", 32'(out_if.data), 32'(e.data));
                check_eq("word_ch", 32'(out_if.ch), 32'(e.ch));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic w, input logic d);
        bclk = 1'b0;
        ws   = w;
        sd   = d;
        wait_clk(HALF);
        bclk = 1'b1;
        wait_clk(HALF);
    endtask

    // Disable, select mode, settle ws_prev at level w, then re-enable
    task automatic preamble(input logic [1:0] m, input logic w);
        enable = 1'b0;
        mode   = m;
        repeat (3) send_bit(w, 1'b0);
        enable = 1'b1;
    endtask

    // I2S slot: one delay bit, WORD_LEN data bits, padding
    task automatic i2s_slot(input int c, input logic [23:0] w, input logic pad, input bit exp);
        if (exp) expect_word(c, w);
        send_bit(c[0], pad);
        for (int j = 1; j < SLOT_LEN; j++)
            send_bit(c[0], (j <= WORD_LEN) ? w[WORD_LEN-j] : pad);
    endtask

    task automatic lj_slot(input int c, input logic [23:0] w, input logic pad);
        expect_word(c, w);
        for (int j = 0; j < SLOT_LEN; j++)
            send_bit(c[0], (j < WORD_LEN) ? w[WORD_LEN-1-j] : pad);
    endtask

    task automatic tdm_frame(input logic [23:0] base);
        for (int k = 0; k < NUM_CH; k++) expect_word(k, base + 24'(k));
        send_bit(1'b1, 1'b0);
        for (int k = 0; k < NUM_CH; k++) begin
            logic [23:0] w;
            w = base + 24'(k);
            for (int j = 0; j < SLOT_LEN; j++)
                send_bit(1'b0, (j < WORD_LEN) ? w[WORD_LEN-1-j] : 1'b0);
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000 && (sb.size() != 0 || out_if.valid); i++) wait_clk(1);
        check_eq(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] w;
        rst          = 1'b1;
        enable       = 1'b0;
        mode         = 2'd0;
        bclk         = 1'b0;
        ws           = 1'b0;
        sd           = 1'b0;
        out_if.ready = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);
        check_eq("rst_data", 32'(out_if.data), 32'd0);
        check_eq("rst_ch", 32'(out_if.ch), 32'd0);
        check_eq("rst_valid", 32'(out_if.valid), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_sync_err", 32'(sync_err), 32'd0);

        // I2S, first word observed cycle-accurately with ready low
        err_base = err_pulses;
        preamble(2'd0, 1'b1);
        w = 24'hA5A5A5;
        expect_word(0, w);
        send_bit(1'b0, 1'b0);
        for (int j = 1; j < WORD_LEN; j++) send_bit(1'b0, w[WORD_LEN-j]);
        bclk = 1'b0;
        sd   = w[0];
        wait_clk(HALF);
        bclk = 1'b1;
        wait_clk(2);
        check_eq("i2s_valid_early", 32'(out_if.valid), 32'd0);
        wait_clk(1);
        check_eq("i2s_valid_rise", 32'(out_if.valid), 32'd1);
        check_eq("i2s_level_one", 32'(level), 32'd1);
        wait_clk(HALF - 3);
        for (int j = WORD_LEN + 1; j < SLOT_LEN; j++) send_bit(1'b0, 1'b0);
        out_if.ready = 1'b1;
        i2s_slot(1, 24'h5A5A5A, 1'b0, 1'b1);
        wait_drain("i2s_drain");
        check_eq("i2s_no_err", 32'(err_pulses - err_base), 32'd0);

        // Left-justified with padding bits at 1
        err_base = err_pulses;
        preamble(2'd1, 1'b1);
        lj_slot(0, 24'hA5A5A5, 1'b1);
        lj_slot(1, 24'h5A5A5A, 1'b1);
        wait_drain("lj_drain");
        check_eq("lj_no_err", 32'(err_pulses - err_base), 32'd0);

        // TDM, two consecutive frames
        err_base = err_pulses;
        preamble(2'd2, 1'b0);
        tdm_frame(24'h100000);
        tdm_frame(24'h100000);
        wait_drain("tdm_drain");
        check_eq("tdm_no_err", 32'(err_pulses - err_base), 32'd0);

        // Overflow: 10 words into an 8-deep FIFO with no consumer
        err_base     = err_pulses;
        out_if.ready = 1'b0;
        preamble(2'd0, 1'b1);
        for (int f = 0; f < 5; f++) begin
            i2s_slot(0, 24'h111000 + 24'(2 * f), 1'b0, (2 * f) < FIFO_DEPTH);
            i2s_slot(1, 24'h111001 + 24'(2 * f), 1'b0, (2 * f + 1) < FIFO_DEPTH);
        end
        wait_clk(4);
        check_eq("ovf_level", 32'(level), 32'd8);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        out_if.ready = 1'b1;
        wait_drain("ovf_drain");
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        check_eq("ovf_no_err", 32'(err_pulses - err_base), 32'd0);

        // Early ws toggle after 10 data bits
        err_base = err_pulses;
        preamble(2'd0, 1'b1);
        w = 24'h3C3C3C;
        send_bit(1'b0, 1'b0);
        for (int j = 1; j <= 10; j++) send_bit(1'b0, w[WORD_LEN-j]);
        i2s_slot(1, 24'h5A5A5A, 1'b0, 1'b1);
        i2s_slot(0, 24'h0C0FFE, 1'b0, 1'b1);
        wait_drain("early_drain");
        check_eq("early_err_once", 32'(err_pulses - err_base), 32'd1);

        // Reset mid-word with three words queued
        err_base     = err_pulses;
        out_if.ready = 1'b0;
        preamble(2'd0, 1'b1);
        i2s_slot(0, 24'h123456, 1'b0, 1'b1);
        i2s_slot(1, 24'h654321, 1'b0, 1'b1);
        i2s_slot(0, 24'hABCDEF, 1'b0, 1'b1);
        for (int j = 0; j < 12; j++) send_bit(1'b1, 1'b1);
        check_eq("rst_pre_level", 32'(level), 32'd3);
        enable = 1'b0;
        rst    = 1'b1;
        wait_clk(1);
        check_eq("rst_mid_valid", 32'(out_if.valid), 32'd0);
        check_eq("rst_mid_level", 32'(level), 32'd0);
        rst = 1'b0;
        sb.delete();
        out_if.ready = 1'b1;
        preamble(2'd0, 1'b1);
        i2s_slot(0, 24'hFEDCBA, 1'b0, 1'b1);
        i2s_slot(1, 24'h0A0B0C, 1'b0, 1'b1);
        wait_drain("rst_drain");
        check_eq("rst_no_err", 32'(err_pulses - err_base), 32'd0);
        check_eq("rst_ovf_clear", 32'(overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
